lif_neuron_update: RTL and testbench
====================================

// Module: lif_neuron_update
// PURPOSE
//  Leaky integrate-and-fire update engine; the stage directly upstream of the single-word neuron potential RAM.
//  Per accepted input current: reads stored membrane potential, applies leak + integration, compares to threshold,
//  emits spike, writes new potential back. Drives the RAM's read_en/write_en/reset_val/init_value/data_in, consumes data_out.
// PARAMETERS
//  RAM_LAT       2            cycles from read_en high to valid data_out (>=1)
//  LEAK_SHIFT    4            leak = v >>> LEAK_SHIFT (arithmetic)
//  THRESHOLD     32'sd1000    spike when v_new >= THRESHOLD (signed)
//  V_RESET       32'sd0       post-spike / init potential
//  REFRAC_CYCLES 2            updates suppressed after a spike (used only with LIF_REFRACTORY_EN)
// PORTS
//  clk         in   1   clock
//  reset       in   1   synchronous, active-high
//  init_req    in   1   request to initialise stored potential to V_RESET
//  in_valid    in   1   input current valid
//  in_ready    out  1   engine can accept (combinational: state==IDLE && !init_req)
//  in_current  in   32  signed input current
//  read_en     out  1   to RAM rden
//  write_en    out  1   to RAM wren
//  reset_val   out  1   to RAM reset_val (selects init_value)
//  init_value  out  32  to RAM init_value; constant V_RESET
//  data_in     out  32  to RAM data_in; new potential
//  data_out    in   32  from RAM q; stored potential
//  spike       out  1   one-cycle pulse, coincident with write-back
//  done        out  1   one-cycle pulse on every write-back (update or init)
// BEHAVIOUR
//  - Reset: state=IDLE; read_en, write_en, reset_val, spike, done = 0; data_in = 0; refractory count = 0. in_ready=1 after reset.
//  - States: IDLE, RD, WT, CALC, WR, INIT.
//    IDLE: init_req -> INIT (init beats in_valid same cycle); else in_valid -> RD, latch in_current.
//    INIT: write_en=1, reset_val=1, done=1 for one cycle -> IDLE. No read.
//    RD: read_en=1 one cycle -> WT (RAM_LAT>1) or CALC (RAM_LAT==1).
//    WT: held RAM_LAT-1 cycles via counter -> CALC.
//    CALC: sample data_out as v; compute in 34-bit signed: v_new = v - (v >>> LEAK_SHIFT) + current;
//          clamp to [0x8000_0000, 0x7FFF_FFFF]; if v_new >= THRESHOLD: v_wr=V_RESET, spk=1; else v_wr=v_new. Register both.
//    WR: write_en=1, data_in=v_wr, spike=spk, done=1, reset_val=0, one cycle -> IDLE.
//  - Accept-to-IDLE latency = RAM_LAT+3 cycles (RAM_LAT=2: accept c0, RD c1, WT c2, CALC c3, WR c4, IDLE c5).
//  - read_en and write_en never high in the same cycle. data_in holds last written value outside WR.
//  - Reset mid-operation (any state): next cycle IDLE, no write issued, RAM content untouched, pending update discarded.
//  - Threshold compare uses clamped value; positive saturation therefore always spikes when THRESHOLD <= 0x7FFF_FFFF.
// CONFIGURATION
//  LIF_REFRACTORY_EN defined: spike loads refr_cnt=REFRAC_CYCLES. While refr_cnt!=0, each accepted update still
//    runs RD..WR but writes V_RESET, spike=0, and decrements refr_cnt. INIT clears refr_cnt.
//  Not defined: no counter, REFRAC_CYCLES ignored, every update integrates.
// STRUCTURE
//  - Shared package neuron_pkg: typedef logic signed [31:0] potential_t; typedef enum state_t
//    {IDLE,RD,WT,CALC,WR,INIT}; constants POT_MAX=32'sh7FFF_FFFF, POT_MIN=32'sh8000_0000.
//  - One sub-module: sat_add_s32 (combinational 3-operand signed add with 32-bit clamp) used by CALC.
//  - Top: FSM, wait counter, operand/result registers, optional refractory counter.
// TESTING (defaults unless stated; RAM model with RAM_LAT=2)
//  1. init_req pulse -> one cycle write_en=1, reset_val=1, done=1, read_en=0; RAM holds 0.
//  2. From 0, current 100 -> writes 100, spike=0; second current 100 -> 100-6+100 = 194 written.
//  3. Stored 950, current 200 -> v_new 950-59+200 = 1091 >= 1000: spike=1, writes 0, in WR cycle (c4).
//  4. Stored -0x7000_0000, current 0x8000_0000 -> clamps, writes 0x8000_0000, spike=0.
//  5. reset asserted in WT -> IDLE next cycle, write_en never asserted, in_ready=1, RAM unchanged; init_req+in_valid same cycle -> INIT.
//  6. LIF_REFRACTORY_EN: after spike, next 2 updates (current 500) write 0, spike=0; 3rd writes 500.

Source files
------------

// File: rtl/neuron_pkg.sv
// Shared types and constants for the LIF neuron update engine.
package neuron_pkg;

  typedef logic signed [31:0] potential_t;

  typedef enum logic [2:0] {IDLE, RD, WT, CALC, WR, INIT} state_t;

  localparam potential_t POT_MAX = 32'sh7FFF_FFFF;
  localparam potential_t POT_MIN = 32'sh8000_0000;

endpackage

// File: rtl/lif_neuron_update_if.sv
// Bus between the LIF update engine (master) and the single-word potential RAM (slave).
interface lif_neuron_update_if;
  import neuron_pkg::*;

  logic       read_en;
  logic       write_en;
  logic       reset_val;
  potential_t init_value;
  potential_t data_in;
  potential_t data_out;

  modport master (
    output read_en, write_en, reset_val, init_value, data_in,
    input  data_out
  );

  modport slave (
    input  read_en, write_en, reset_val, init_value, data_in,
    output data_out
  );

endinterface

// File: rtl/sat_add_s32.sv
// Three-operand signed add computed at 34 bits, clamped to the signed 32-bit range.
module sat_add_s32
  import neuron_pkg::*;
(
  input  potential_t a_i,
  input  potential_t b_i,
  input  potential_t c_i,
  output potential_t sum_o
);

  logic signed [33:0] sum_wide;

  always_comb begin
    sum_wide = {{2{a_i[31]}}, a_i} + {{2{b_i[31]}}, b_i} + {{2{c_i[31]}}, c_i};
    if (sum_wide > 34'(POT_MAX)) begin
      sum_o = POT_MAX;
    end else if (sum_wide < 34'(POT_MIN)) begin
      sum_o = POT_MIN;
    end else begin
      sum_o = sum_wide[31:0];
    end
  end

endmodule

// File: rtl/lif_neuron_update.sv
// Leaky integrate-and-fire update engine driving a single-word potential RAM.
// Optional refractory period enabled by defining LIF_REFRACTORY_EN.
module lif_neuron_update
  import neuron_pkg::*;
#(
  parameter int unsigned RAM_LAT       = 2,
  parameter int unsigned LEAK_SHIFT    = 4,
  parameter potential_t  THRESHOLD     = 32'sd1000,
  parameter potential_t  V_RESET       = 32'sd0,
  parameter int unsigned REFRAC_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       init_req,
  input  logic       in_valid,
  output logic       in_ready,
  input  potential_t in_current,
  output logic       spike,
  output logic       done,
  lif_neuron_update_if.master ram
);

  state_t     state_q;
  logic [7:0] wait_q;
  potential_t cur_q;
  logic       rd_q;
  logic       wr_q;
  logic       rst_val_q;
  logic       spike_q;
  logic       done_q;
  potential_t data_in_q;

  potential_t v;
  potential_t leak_neg;
  potential_t v_new;
  logic       spk;

  assign v        = ram.data_out;
  assign leak_neg = -(v >>> LEAK_SHIFT);

  sat_add_s32 u_sat_add (
    .a_i   (v),
    .b_i   (leak_neg),
    .c_i   (cur_q),
    .sum_o (v_new)
  );

  assign spk = (v_new >= THRESHOLD);

`ifdef LIF_REFRACTORY_EN
  logic [15:0] refr_q;
`else
  logic unused_refrac;
  assign unused_refrac = ^REFRAC_CYCLES;
`endif

  // Outputs are registered: each transition loads the values for the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      wait_q    <= '0;
      cur_q     <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      rst_val_q <= 1'b0;
      spike_q   <= 1'b0;
      done_q    <= 1'b0;
      data_in_q <= '0;
`ifdef LIF_REFRACTORY_EN
      refr_q    <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (init_req) begin
            state_q   <= INIT;
            wr_q      <= 1'b1;
            rst_val_q <= 1'b1;
            done_q    <= 1'b1;
          end else if (in_valid) begin
            state_q <= RD;
            cur_q   <= in_current;
            rd_q    <= 1'b1;
          end
        end
        RD: begin
          rd_q <= 1'b0;
          if (RAM_LAT > 1) begin
            state_q <= WT;
            wait_q  <= 8'(RAM_LAT - 2);
          end else begin
            state_q <= CALC;
          end
        end
        WT: begin
          if (wait_q == '0) begin
            state_q <= CALC;
          end else begin
            wait_q <= wait_q - 8'd1;
          end
        end
        CALC: begin
          state_q <= WR;
          wr_q    <= 1'b1;
          done_q  <= 1'b1;
`ifdef LIF_REFRACTORY_EN
          if (refr_q != '0) begin
            data_in_q <= V_RESET;
            spike_q   <= 1'b0;
            refr_q    <= refr_q - 16'd1;
          end else begin
            data_in_q <= spk ? V_RESET : v_new;
            spike_q   <= spk;
            if (spk) begin
              refr_q <= 16'(REFRAC_CYCLES);
            end
          end
`else
          data_in_q <= spk ? V_RESET : v_new;
          spike_q   <= spk;
`endif
        end
        WR: begin
          state_q <= IDLE;
          wr_q    <= 1'b0;
          spike_q <= 1'b0;
          done_q  <= 1'b0;
        end
        INIT: begin
          state_q   <= IDLE;
          wr_q      <= 1'b0;
          rst_val_q <= 1'b0;
          done_q    <= 1'b0;
`ifdef LIF_REFRACTORY_EN
          refr_q    <= '0;
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready       = (state_q == IDLE) && !init_req;
  assign spike          = spike_q;
  assign done           = done_q;
  assign ram.read_en    = rd_q;
  assign ram.write_en   = wr_q;
  assign ram.reset_val  = rst_val_q;
  assign ram.init_value = V_RESET;
  assign ram.data_in    = data_in_q;

endmodule

// File: tb/tb_lif_neuron_update.sv
// Scoreboard bench for lif_neuron_update with a RAM_LAT=2 single-word RAM model.
module tb_lif_neuron_update;
  import neuron_pkg::*;

  typedef struct {
    logic       is_init;
    potential_t data;
    logic       spk;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       init_req = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  potential_t in_current = '0;
  logic       spike;
  logic       done;

  lif_neuron_update_if ram_if ();

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  // RAM model state (backdoor preload goes through bd_en to keep a single writer)
  potential_t mem = 32'h1234_5678;
  potential_t pipe1 = '0;
  logic       bd_en = 1'b0;
  potential_t bd_val = '0;

  lif_neuron_update #(
    .RAM_LAT       (2),
    .LEAK_SHIFT    (4),
    .THRESHOLD     (32'sd1000),
    .V_RESET       (32'sd0),
    .REFRAC_CYCLES (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .init_req   (init_req),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_current (in_current),
    .spike      (spike),
    .done       (done),
    .ram        (ram_if)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bd_en) mem <= bd_val;
    else if (ram_if.write_en) mem <= ram_if.reset_val ? ram_if.init_value : ram_if.data_in;
    if (ram_if.read_en) pipe1 <= mem;
    ram_if.data_out <= pipe1;
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: every write-back cycle must match the oldest expected entry.
  always @(negedge clk) begin
    if (!reset && (ram_if.write_en || done || spike)) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: we=%b done=%b spike=%b data_in=%h at %0t",
                 ram_if.write_en, done, spike, ram_if.data_in, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("wb_write_en", {31'd0, ram_if.write_en}, 32'd1);
        chk("wb_done", {31'd0, done}, 32'd1);
        chk("wb_read_en_low", {31'd0, ram_if.read_en}, 32'd0);
        chk("wb_reset_val", {31'd0, ram_if.reset_val}, {31'd0, e.is_init});
        chk("wb_spike", {31'd0, spike}, {31'd0, e.spk});
        if (e.is_init) chk("wb_init_value", ram_if.init_value, e.data);
        else           chk("wb_data_in", ram_if.data_in, e.data);
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ready_timeout", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic backdoor(input potential_t val);
    bd_val = val;
    bd_en  = 1'b1;
    @(posedge clk); #1;
    bd_en  = 1'b0;
  endtask

  task automatic do_init();
    wait_ready();
    init_req = 1'b1;
    sb.push_back('{1'b1, 32'sd0, 1'b0});
    @(posedge clk); #1;
    init_req = 1'b0;
    chk("init_read_en", {31'd0, ram_if.read_en}, 32'd0);
    @(posedge clk); #1;
    chk("init_mem", mem, 32'd0);
  endtask

  task automatic do_update(input potential_t cur, input potential_t exp_v, input logic exp_s);
    wait_ready();
    in_valid   = 1'b1;
    in_current = cur;
    sb.push_back('{1'b0, exp_v, exp_s});
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("wb_latency", {31'd0, done}, 32'd1);
    @(posedge clk); #1;
    chk("idle_after_wb", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    ram_if.data_out = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_read_en", {31'd0, ram_if.read_en}, 32'd0);
    chk("rst_write_en", {31'd0, ram_if.write_en}, 32'd0);
    chk("rst_reset_val", {31'd0, ram_if.reset_val}, 32'd0);
    chk("rst_spike_done", {30'd0, spike, done}, 32'd0);
    chk("rst_data_in", ram_if.data_in, 32'd0);
    reset = 1'b0;
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;

    do_init();
    do_update(32'sd100, 32'sd100, 1'b0);
    do_update(32'sd100, 32'sd194, 1'b0);

    backdoor(32'sd950);
    do_update(32'sd200, 32'sd0, 1'b1);
    do_init();

    backdoor(-32'sh7000_0000);
    do_update(32'sh8000_0000, 32'sh8000_0000, 1'b0);

    backdoor(32'sd0);
    do_update(32'sd1000, 32'sd0, 1'b1);
    do_init();
    backdoor(32'sd0);
    do_update(32'sd999, 32'sd999, 1'b0);
    backdoor(-32'sd1600);
    do_update(32'sd0, -32'sd1500, 1'b0);
    backdoor(32'sh7FFF_FFF0);
    do_update(32'sh7FFF_FFFF, 32'sd0, 1'b1);
    do_init();

    // Reset while waiting on RAM data: update must be dropped without a write.
    backdoor(32'sd500);
    wait_ready();
    in_valid   = 1'b1;
    in_current = 32'sd100;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_write_en", {31'd0, ram_if.write_en}, 32'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("midrst_mem", mem, 32'd500);

    // init_req wins over in_valid in the same cycle.
    wait_ready();
    init_req   = 1'b1;
    in_valid   = 1'b1;
    in_current = 32'sd777;
    sb.push_back('{1'b1, 32'sd0, 1'b0});
    @(posedge clk); #1;
    init_req = 1'b0;
    in_valid = 1'b0;
    chk("combo_reset_val", {31'd0, ram_if.reset_val}, 32'd1);
    @(posedge clk); #1;
    chk("combo_no_read", {31'd0, ram_if.read_en}, 32'd0);
    chk("combo_mem", mem, 32'd0);

`ifdef LIF_REFRACTORY_EN
    backdoor(32'sd950);
    do_update(32'sd200, 32'sd0, 1'b1);
    do_update(32'sd500, 32'sd0, 1'b0);
    do_update(32'sd500, 32'sd0, 1'b0);
    do_update(32'sd500, 32'sd500, 1'b0);
`endif

    repeat (5) @(posedge clk);
    #1;
    chk("sb_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
